// File: rtl/score_bcd_counter.sv
// Two-digit BCD snake score with a session best. Apple events are queued and
// committed one per frame_end, so the digits only move between scanned frames.
module score_bcd_counter #(
  parameter int unsigned INC_STEP = 1,
  parameter int unsigned PEND_MAX = 3
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       game_restart,
  input  logic       apple_eaten,
  input  logic       frame_end,
  output logic [3:0] score_tens,
  output logic [3:0] score_units,
  output logic [3:0] best_tens,
  output logic [3:0] best_units,
  output logic       score_changed,
  output logic       new_record,
  output logic       max_reached
);
  localparam logic [4:0] STEP = 5'(INC_STEP);
  localparam logic [2:0] PMAX = 3'(PEND_MAX);

  logic       apple_q;
  logic [2:0] pend_q, pend_d;
  logic [3:0] tens_q, units_q, tens_d, units_d;
  logic [3:0] best_tens_q, best_units_q;
  logic       chg_q, rec_q, max_q;

  logic       edge_w, commit, at_max, bump, carry, ovf;
  logic [4:0] usum;
  logic [3:0] psum;

  assign edge_w = apple_eaten & ~apple_q;
  assign commit = frame_end & ((pend_q != 3'd0) | edge_w);
  assign at_max = (tens_q == 4'd9) && (units_q == 4'd9);
  assign bump   = commit && !at_max;

  always_comb begin
    usum    = {1'b0, units_q} + STEP;
    carry   = usum > 5'd9;
    ovf     = carry && (tens_q == 4'd9);
    tens_d  = ovf ? 4'd9 : tens_q + {3'b000, carry};
    units_d = ovf ? 4'd9 : (carry ? 4'(usum - 5'd10) : usum[3:0]);
    // A simultaneous edge and commit nets out, so pending can never underflow.
    psum    = {1'b0, pend_q} + {3'b000, edge_w} - {3'b000, commit};
    pend_d  = (psum > {1'b0, PMAX}) ? PMAX : psum[2:0];
  end

  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      apple_q      <= 1'b0;
      pend_q       <= '0;
      tens_q       <= '0;
      units_q      <= '0;
      best_tens_q  <= '0;
      best_units_q <= '0;
      chg_q        <= 1'b0;
      rec_q        <= 1'b0;
      max_q        <= 1'b0;
    end else if (game_restart) begin
      apple_q <= 1'b0;
      pend_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
      chg_q   <= 1'b0;
      rec_q   <= 1'b0;
      max_q   <= 1'b0;
    end else begin
      apple_q <= apple_eaten;
      pend_q  <= pend_d;
      chg_q   <= bump;
      if (bump) begin
        tens_q  <= tens_d;
        units_q <= units_d;
        if (tens_d == 4'd9 && units_d == 4'd9) max_q <= 1'b1;
      end
      // Packed BCD compares in numeric order, so no binary conversion is needed.
      if (chg_q && ({tens_q, units_q} > {best_tens_q, best_units_q})) begin
        best_tens_q  <= tens_q;
        best_units_q <= units_q;
        rec_q        <= 1'b1;
      end
    end
  end

  assign score_tens    = tens_q;
  assign score_units   = units_q;
  assign best_tens     = best_tens_q;
  assign best_units    = best_units_q;
  assign score_changed = chg_q;
  assign new_record    = rec_q;
  assign max_reached   = max_q;
endmodule
